array_edge_sink: RTL and testbench

ARRAY_EDGE_SINK -- requirements
Module: array_edge_sink

---
 rtl/array_edge_sink.sv | 82 ++++++++
 tb/tb_array_edge_sink.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/array_edge_sink.sv
// Edge sink for an element array: buffers the 16-bit payload of a 64-bit element word in a DEPTH-entry FIFO.
// Optional upper-bit zero check is enabled by defining ARRAY_EDGE_SINK_ZCHECK_EN.
module array_edge_sink #(
  parameter int DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [63:0]               io_in,
  input  logic                      io_in_valid,
  output logic                      io_deq_valid,
  input  logic                      io_deq_ready,
  output logic [15:0]               io_deq_bits,
  output logic [$clog2(DEPTH):0]    io_level,
  output logic [7:0]                io_drops,
  output logic                      io_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic [7:0]    drops;
  logic          deq;
  logic          enq;
  logic          drop;

  // Handshake: the head leaves when io_deq_valid && io_deq_ready at a clock edge;
  // io_in_valid has no back-pressure, so a sample that finds no room is counted and lost.
  always_comb begin
    deq  = (level != '0) && io_deq_ready;
    enq  = io_in_valid && ((level != FULL_LEVEL) || deq);
    drop = io_in_valid && !enq;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      drops  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop && (drops != 8'hFF)) drops <= drops + 1'b1;
    end
  end

  // Storage needs no reset; level alone decides which entries are meaningful.
  always_ff @(posedge clock) begin
    if (!reset && enq) mem[wr_ptr] <= io_in[15:0];
  end

  assign io_deq_valid = (level != '0);
  assign io_deq_bits  = io_deq_valid ? mem[rd_ptr] : 16'h0000;
  assign io_level     = level;
  assign io_drops     = drops;

`ifdef ARRAY_EDGE_SINK_ZCHECK_EN
  logic err;

  always_ff @(posedge clock) begin
    if (reset)                                  err <= 1'b0;
    else if (io_in_valid && (io_in[63:16] != '0)) err <= 1'b1;
  end

  assign io_err = err;
`else
  logic unused_upper;

  assign unused_upper = ^io_in[63:16];
  assign io_err       = 1'b0;
`endif

endmodule

// File: tb/tb_array_edge_sink.sv
// Directed bench for array_edge_sink (DEPTH=4): hand-computed vectors plus a small FIFO model.
// Builds with or without ARRAY_EDGE_SINK_ZCHECK_EN; the expected io_err follows the macro.
module tb_array_edge_sink;

  localparam int DEPTH = 4;
`ifdef ARRAY_EDGE_SINK_ZCHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [63:0] io_in;
  logic        io_in_valid;
  logic        io_deq_valid;
  logic        io_deq_ready;
  logic [15:0] io_deq_bits;
  logic [2:0]  io_level;
  logic [7:0]  io_drops;
  logic        io_err;

  array_edge_sink #(.DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in        (io_in),
    .io_in_valid  (io_in_valid),
    .io_deq_valid (io_deq_valid),
    .io_deq_ready (io_deq_ready),
    .io_deq_bits  (io_deq_bits),
    .io_level     (io_level),
    .io_drops     (io_drops),
    .io_err       (io_err)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required finish before limit");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [15:0] exp_q[$];
  int          exp_drops;
  bit          exp_err;
  int          n_checks;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One clock cycle of stimulus with the model updated alongside; outputs checked after the edge.
  task automatic cycle(input logic v, input logic [63:0] d, input logic rdy);
    bit deq;
    bit enq;
    deq = (exp_q.size() != 0) && rdy;
    enq = v && ((exp_q.size() < DEPTH) || deq);
    io_in_valid  = v;
    io_in        = d;
    io_deq_ready = rdy;
    if (deq) begin
      check("pop_data", 32'(io_deq_bits), 32'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    if (enq) exp_q.push_back(d[15:0]);
    else if (v && exp_drops != 255) exp_drops++;
    if (ZCHK && v && (d[63:16] != 48'h0)) exp_err = 1'b1;
    step();
    io_in_valid  = 1'b0;
    io_in        = 64'h0;
    io_deq_ready = 1'b0;
    check("level", 32'(io_level), 32'(exp_q.size()));
    check("valid", 32'(io_deq_valid), 32'(exp_q.size() != 0));
    check("head", 32'(io_deq_bits), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
    check("drops", 32'(io_drops), 32'(exp_drops));
    check("err", 32'(io_err), 32'(exp_err));
  endtask

  // Reset pulse with a sample presented that must not be accepted.
  task automatic pulse_reset(input int cycles);
    reset        = 1'b1;
    io_in_valid  = 1'b1;
    io_in        = 64'h0000_0000_0000_7777;
    io_deq_ready = 1'b1;
    repeat (cycles) step();
    reset        = 1'b0;
    io_in_valid  = 1'b0;
    io_in        = 64'h0;
    io_deq_ready = 1'b0;
    exp_q.delete();
    exp_drops = 0;
    exp_err   = 1'b0;
    check("rst_level", 32'(io_level), 32'h0);
    check("rst_valid", 32'(io_deq_valid), 32'h0);
    check("rst_bits", 32'(io_deq_bits), 32'h0);
    check("rst_drops", 32'(io_drops), 32'h0);
    check("rst_err", 32'(io_err), 32'h0);
  endtask

  logic [15:0] drain_exp [4];

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    exp_drops    = 0;
    exp_err      = 1'b0;
    reset        = 1'b1;
    io_in        = 64'h0;
    io_in_valid  = 1'b0;
    io_deq_ready = 1'b0;

    pulse_reset(2);

    // single word through with ready held high
    cycle(1'b1, 64'h1234, 1'b1);
    check("one_valid", 32'(io_deq_valid), 32'h1);
    check("one_bits", 32'(io_deq_bits), 32'h1234);
    cycle(1'b0, 64'h0, 1'b1);
    check("one_level0", 32'(io_level), 32'h0);

    // overfill: 6 samples into DEPTH=4
    for (int i = 1; i <= 6; i++) cycle(1'b1, 64'(i), 1'b0);
    check("ovf_level", 32'(io_level), 32'h4);
    check("ovf_drops", 32'(io_drops), 32'h2);
    cycle(1'b0, 64'h0, 1'b0);
    check("hold_bits", 32'(io_deq_bits), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      check("drain_order", 32'(io_deq_bits), 32'(i));
      cycle(1'b0, 64'h0, 1'b1);
    end
    check("drain_empty", 32'(io_deq_valid), 32'h0);
    cycle(1'b0, 64'h0, 1'b1);
    check("empty_ready", 32'(io_level), 32'h0);

    // full FIFO with simultaneous enqueue and dequeue
    cycle(1'b1, 64'h11, 1'b0);
    cycle(1'b1, 64'h22, 1'b0);
    cycle(1'b1, 64'h33, 1'b0);
    cycle(1'b1, 64'h44, 1'b0);
    cycle(1'b1, 64'hAAAA, 1'b1);
    check("full_swap_level", 32'(io_level), 32'h4);
    check("full_swap_drops", 32'(io_drops), 32'h2);
    drain_exp[0] = 16'h0022;
    drain_exp[1] = 16'h0033;
    drain_exp[2] = 16'h0044;
    drain_exp[3] = 16'hAAAA;
    for (int i = 0; i < 4; i++) begin
      check("swap_order", 32'(io_deq_bits), 32'(drain_exp[i]));
      cycle(1'b0, 64'h0, 1'b1);
    end

    // upper-bit check
    cycle(1'b1, 64'h0001_0000_0000_0005, 1'b0);
    check("zchk_err", 32'(io_err), 32'(ZCHK));
    check("zchk_word", 32'(io_deq_bits), 32'h5);
    cycle(1'b0, 64'h0, 1'b1);
    cycle(1'b1, 64'h0000_0000_0000_0009, 1'b1);
    cycle(1'b0, 64'h0, 1'b1);
    check("zchk_sticky", 32'(io_err), 32'(ZCHK));

    // reset mid-operation discards buffered words and clears counters
    cycle(1'b1, 64'hA1, 1'b0);
    cycle(1'b1, 64'hA2, 1'b0);
    cycle(1'b1, 64'hA3, 1'b0);
    check("pre_rst_level", 32'(io_level), 32'h3);
    pulse_reset(1);
    cycle(1'b1, 64'h00FF, 1'b0);
    check("post_rst_first", 32'(io_deq_bits), 32'h00FF);
    check("post_rst_level", 32'(io_level), 32'h1);
    cycle(1'b0, 64'h0, 1'b1);

    // drop counter saturation
    for (int i = 0; i < 300; i++) cycle(1'b1, 64'(16'h100 + i), 1'b0);
    check("sat_level", 32'(io_level), 32'h4);
    check("sat_drops", 32'(io_drops), 32'd255);
    check("sat_head", 32'(io_deq_bits), 32'h0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
